// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Produces the pixel position,
// sync pulses, blanking flag and line/frame start strobes from a single
// system clock, with an integer clock-to-pixel divider and a pause input.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   i_enable       1 = timing runs, 0 = all state frozen
//   o_pix_en       pixel-advance strobe (combinational from divider state)
//   hpos, vpos     current pixel column / line
//   o_hsync        horizontal sync at the H_SYNC_POL level
//   o_vsync        vertical sync at the V_SYNC_POL level
//   visible        current pixel lies in the active area
//   hmax, vmax     hpos / vpos sit on their last value
//   o_line_start   one-clk registered pulse after hpos wraps to 0
//   o_frame_start  one-clk registered pulse after vpos wraps to 0
//   o_frame_count  completed frames, mod 256
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VIEW     = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VIEW     = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_enable,
  output logic         o_pix_en,
  output logic [W-1:0] hpos,
  output logic [W-1:0] vpos,
  output logic         o_hsync,
  output logic         o_vsync,
  output logic         visible,
  output logic         hmax,
  output logic         vmax,
  output logic         o_line_start,
  output logic         o_frame_start,
  output logic [7:0]   o_frame_count
);

  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  // A divider of 1 still needs a one-bit counter so the port logic stays
  // uniform; it simply never leaves zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [W-1:0]     H_LAST   = W'(H_TOTAL - 1);
  localparam logic [W-1:0]     V_LAST   = W'(V_TOTAL - 1);

  localparam int HS_START = H_VIEW + H_FRONT;
  localparam int HS_END   = H_VIEW + H_FRONT + H_SYNC;
  localparam int VS_START = V_VIEW + V_FRONT;
  localparam int VS_END   = V_VIEW + V_FRONT + V_SYNC;

  logic [DIV_W-1:0] div_cnt;
  logic             hsync_active;
  logic             vsync_active;

  // The pixel strobe fires on the last divider phase, but only while
  // enabled, so a pause also suppresses any counter advance.
  assign o_pix_en = i_enable && (div_cnt == DIV_LAST);

  // Clock divider: counts enabled clocks and wraps on the last phase. When
  // paused it holds, so counting resumes exactly where it stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (i_enable) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters, frame counter and start strobes. The strobes default
  // low every clock so each pulse lasts exactly one cycle, even if the
  // generator is paused right after the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpos          <= '0;
      vpos          <= '0;
      o_frame_count <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      if (o_pix_en) begin
        if (hpos != H_LAST) begin
          hpos <= hpos + W'(1);
        end else begin
          hpos         <= '0;
          o_line_start <= 1'b1;
          if (vpos != V_LAST) begin
            vpos <= vpos + W'(1);
          end else begin
            vpos          <= '0;
            o_frame_start <= 1'b1;
            o_frame_count <= o_frame_count + 8'd1;
          end
        end
      end
    end
  end

  // Decodes are taken straight from the registered counters so they line
  // up with hpos/vpos on the same cycle. Compares are done at int width so
  // a sync window ending exactly at the total cannot overflow W bits.
  assign visible      = (int'(hpos) < H_VIEW) && (int'(vpos) < V_VIEW);
  assign hsync_active = (int'(hpos) >= HS_START) && (int'(hpos) < HS_END);
  assign vsync_active = (int'(vpos) >= VS_START) && (int'(vpos) < VS_END);
  assign o_hsync      = hsync_active ? H_SYNC_POL : ~H_SYNC_POL;
  assign o_vsync      = vsync_active ? V_SYNC_POL : ~V_SYNC_POL;
  assign hmax         = (hpos == H_LAST);
  assign vmax         = (vpos == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances of the timing generator: a tiny raster with active-high
// syncs and no divider (dut_a), and a small raster with active-low syncs
// and a divide-by-3 pixel clock (dut_b). A reference model predicts every
// output per clock from a linear pixel count; predictions are queued when
// the stimulus for a clock is driven and compared by a monitor after the
// edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, div;
    bit hp, vp;
  } geom_t;

  // flags = {hsync, vsync, visible, hmax, vmax, line_start, frame_start, pix_en}
  typedef struct {
    int         id;
    int         hpos;
    int         vpos;
    int         fc;
    logic [7:0] flags;
  } exp_t;

  logic clk;
  logic rst_a, en_a, rst_b, en_b;

  logic       a_pe, a_hs, a_vs, a_vis, a_hmax, a_vmax, a_ls, a_fs;
  logic [3:0] a_hpos, a_vpos;
  logic [7:0] a_fc;
  logic       b_pe, b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs;
  logic [5:0] b_hpos, b_vpos;
  logic [7:0] b_fc;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_n[2];
  int   m_d[2];
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_o;

  vga_timing_gen #(
    .H_VIEW(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VIEW(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1), .W(4)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .i_enable(en_a), .o_pix_en(a_pe),
    .hpos(a_hpos), .vpos(a_vpos), .o_hsync(a_hs), .o_vsync(a_vs),
    .visible(a_vis), .hmax(a_hmax), .vmax(a_vmax), .o_line_start(a_ls),
    .o_frame_start(a_fs), .o_frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VIEW(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIEW(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(3), .W(6)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .i_enable(en_b), .o_pix_en(b_pe),
    .hpos(b_hpos), .vpos(b_vpos), .o_hsync(b_hs), .o_vsync(b_vs),
    .visible(b_vis), .hmax(b_hmax), .vmax(b_vmax), .o_line_start(b_ls),
    .o_frame_start(b_fs), .o_frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic geom_t get_geom(input int id);
    geom_t g;
    if (id == 0) begin
      g.hv = 4;  g.hf = 1; g.hs = 1; g.hb = 1;
      g.vv = 2;  g.vf = 1; g.vs = 1; g.vb = 1;
      g.div = 1; g.hp = 1'b1; g.vp = 1'b1;
    end else begin
      g.hv = 16; g.hf = 2; g.hs = 3; g.hb = 2;
      g.vv = 6;  g.vf = 1; g.vs = 2; g.vb = 1;
      g.div = 3; g.hp = 1'b0; g.vp = 1'b0;
    end
    return g;
  endfunction

  function automatic exp_t get_obs(input int id);
    exp_t o;
    o.id = id;
    if (id == 0) begin
      o.hpos  = int'(a_hpos);
      o.vpos  = int'(a_vpos);
      o.fc    = int'(a_fc);
      o.flags = {a_hs, a_vs, a_vis, a_hmax, a_vmax, a_ls, a_fs, a_pe};
    end else begin
      o.hpos  = int'(b_hpos);
      o.vpos  = int'(b_vpos);
      o.fc    = int'(b_fc);
      o.flags = {b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs, b_pe};
    end
    return o;
  endfunction

  // Advances the model of one DUT across the next clock edge, queues the
  // prediction, then waits for the edge so the monitor can compare.
  task automatic drive_cycle(input int id);
    geom_t g;
    exp_t  e;
    int    ht, vt, hp, vp;
    bit    en, rn, pe_pre, ls, fs, pe, hs_act, vs_act;
    g  = get_geom(id);
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    en = (id == 0) ? en_a : en_b;
    rn = (id == 0) ? rst_a : rst_b;
    ls = 1'b0;
    fs = 1'b0;
    if (!rn) begin
      m_n[id] = 0;
      m_d[id] = 0;
    end else begin
      pe_pre = en && (m_d[id] == g.div - 1);
      if (en) m_d[id] = (m_d[id] + 1) % g.div;
      ls = pe_pre && ((m_n[id] % ht) == ht - 1);
      fs = ls && (((m_n[id] / ht) % vt) == vt - 1);
      if (pe_pre) m_n[id]++;
    end
    hp     = m_n[id] % ht;
    vp     = (m_n[id] / ht) % vt;
    pe     = en && (m_d[id] == g.div - 1);
    hs_act = (hp >= g.hv + g.hf) && (hp < g.hv + g.hf + g.hs);
    vs_act = (vp >= g.vv + g.vf) && (vp < g.vv + g.vf + g.vs);
    e.id    = id;
    e.hpos  = hp;
    e.vpos  = vp;
    e.fc    = (m_n[id] / (ht * vt)) % 256;
    e.flags = {hs_act ? g.hp : ~g.hp, vs_act ? g.vp : ~g.vp,
               (hp < g.hv) && (vp < g.vv), hp == ht - 1, vp == vt - 1,
               ls, fs, pe};
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: pops every prediction queued for this edge and
  // compares it against the DUT shortly after the edge.
  always @(posedge clk) begin
    #1;
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_o = get_obs(mon_e.id);
      n_checks++;
      if (mon_o.hpos !== mon_e.hpos) begin
        n_errors++;
        if (n_errors <= 40)
          $display("[TB] FAIL sb_hpos dut%0d t=%0t: got %0d expected %0d", mon_e.id, $time, mon_o.hpos, mon_e.hpos);
      end
      n_checks++;
      if (mon_o.vpos !== mon_e.vpos) begin
        n_errors++;
        if (n_errors <= 40)
          $display("[TB] FAIL sb_vpos dut%0d t=%0t: got %0d expected %0d", mon_e.id, $time, mon_o.vpos, mon_e.vpos);
      end
      n_checks++;
      if (mon_o.fc !== mon_e.fc) begin
        n_errors++;
        if (n_errors <= 40)
          $display("[TB] FAIL sb_frame_count dut%0d t=%0t: got %0d expected %0d", mon_e.id, $time, mon_o.fc, mon_e.fc);
      end
      n_checks++;
      if (mon_o.flags !== mon_e.flags) begin
        n_errors++;
        if (n_errors <= 40)
          $display("[TB] FAIL sb_flags(hs,vs,vis,hmax,vmax,ls,fs,pe) dut%0d t=%0t: got %b expected %b", mon_e.id, $time, mon_o.flags, mon_e.flags);
      end
    end
  end

  task automatic test_reset;
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;
    m_n[0] = 0; m_d[0] = 0; m_n[1] = 0; m_d[1] = 0;
    #2;
    n_checks++;
    if ({a_hpos, a_vpos, a_fc} !== 16'd0 || {a_hs, a_vs, a_vis, a_hmax, a_vmax, a_ls, a_fs, a_pe} !== 8'b00100001) begin
      n_errors++;
      $display("[TB] FAIL reset_a: got pos=%0d/%0d fc=%0d flags=%b expected 0/0 fc=0 flags=00100001", a_hpos, a_vpos, a_fc, {a_hs, a_vs, a_vis, a_hmax, a_vmax, a_ls, a_fs, a_pe});
    end
    n_checks++;
    if ({b_hpos, b_vpos, b_fc} !== 20'd0 || {b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs, b_pe} !== 8'b11100000) begin
      n_errors++;
      $display("[TB] FAIL reset_b: got pos=%0d/%0d fc=%0d flags=%b expected 0/0 fc=0 flags=11100000", b_hpos, b_vpos, b_fc, {b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs, b_pe});
    end
    for (int i = 0; i < 3; i++) drive_cycle(0);
    for (int i = 0; i < 3; i++) drive_cycle(1);
  endtask

  // 7x5 raster run for 257 frames to take the frame counter through 255->0.
  task automatic test_small_geometry;
    int         vis_cnt, frames, wraps;
    logic [7:0] prev_fc;
    vis_cnt = 0; frames = 0; wraps = 0; prev_fc = 8'd0;
    rst_a = 1'b1;
    for (int i = 0; i < 257 * 35; i++) begin
      drive_cycle(0);
      if (i < 35 && a_vis) vis_cnt++;
      if (a_fs) begin
        frames++;
        n_checks++;
        if (!(a_ls === 1'b1 && a_hpos === 4'd0 && a_vpos === 4'd0)) begin
          n_errors++;
          $display("[TB] FAIL frame_start_align: got ls=%b pos=%0d/%0d expected ls=1 pos=0/0", a_ls, a_hpos, a_vpos);
        end
      end
      if (a_fc !== prev_fc) begin
        n_checks++;
        if (a_fc !== prev_fc + 8'd1) begin
          n_errors++;
          $display("[TB] FAIL frame_count_step: got %0d expected %0d", a_fc, prev_fc + 8'd1);
        end
        if (a_fc === 8'd0) wraps++;
        prev_fc = a_fc;
      end
    end
    n_checks++;
    if (vis_cnt !== 8) begin
      n_errors++;
      $display("[TB] FAIL visible_per_frame: got %0d expected 8", vis_cnt);
    end
    n_checks++;
    if (frames !== 257) begin
      n_errors++;
      $display("[TB] FAIL frame_start_count: got %0d expected 257", frames);
    end
    n_checks++;
    if (wraps !== 1) begin
      n_errors++;
      $display("[TB] FAIL frame_count_wraps: got %0d expected 1", wraps);
    end
    n_checks++;
    if (a_fc !== 8'd1) begin
      n_errors++;
      $display("[TB] FAIL frame_count_end: got %0d expected 1", a_fc);
    end
    en_a = 1'b0;
  endtask

  // Divide-by-3 raster over two full frames: pixel strobe every third clk,
  // line start every 69 clks and one clk wide.
  task automatic test_divider;
    int pe_cnt, ls_cnt, last_ls, bad_gap;
    bit prev_ls;
    pe_cnt = 0; ls_cnt = 0; last_ls = -1; bad_gap = 0; prev_ls = 1'b0;
    rst_b = 1'b1;
    for (int i = 0; i < 1380; i++) begin
      drive_cycle(1);
      if (b_pe) pe_cnt++;
      if (b_ls) begin
        ls_cnt++;
        if (prev_ls) bad_gap++;
        if (last_ls < 0 && i != 68) bad_gap++;
        if (last_ls >= 0 && i - last_ls != 69) bad_gap++;
        last_ls = i;
      end
      prev_ls = b_ls;
    end
    n_checks++;
    if (pe_cnt !== 460) begin
      n_errors++;
      $display("[TB] FAIL pix_en_count: got %0d expected 460", pe_cnt);
    end
    n_checks++;
    if (ls_cnt !== 20) begin
      n_errors++;
      $display("[TB] FAIL line_start_count: got %0d expected 20", ls_cnt);
    end
    n_checks++;
    if (bad_gap !== 0) begin
      n_errors++;
      $display("[TB] FAIL line_start_spacing: got %0d bad pulses expected 0", bad_gap);
    end
  endtask

  // Pause at hpos=10, vpos=5 for 50 clks; the next line start should be
  // 13 pixels * 3 clks + 50 = 89 clks after the pause began.
  task automatic test_pause;
    int  cnt;
    bit  found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      drive_cycle(1);
      if (b_hpos === 6'd10 && b_vpos === 6'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("[TB] FAIL pause_reach: got timeout expected hpos=10 vpos=5");
    end
    en_b = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1);
      cnt++;
    end
    en_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      drive_cycle(1);
      cnt++;
      if (b_ls) found = 1'b1;
    end
    n_checks++;
    if (!found || cnt !== 89) begin
      n_errors++;
      $display("[TB] FAIL pause_line_start: got %0d clks (found=%0d) expected 89", cnt, found);
    end
  endtask

  // Asynchronous reset mid-clock at hpos=20, vpos=8; outputs must clear
  // before the next edge and the first strobe follows 23*3 clks later.
  task automatic test_reset_async;
    int cnt;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      drive_cycle(1);
      if (b_hpos === 6'd20 && b_vpos === 6'd8) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("[TB] FAIL reset_reach: got timeout expected hpos=20 vpos=8");
    end
    #1;
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({b_hpos, b_vpos, b_fc} !== 20'd0 || {b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs, b_pe} !== 8'b11100000) begin
      n_errors++;
      $display("[TB] FAIL async_reset: got pos=%0d/%0d fc=%0d flags=%b expected 0/0 fc=0 flags=11100000", b_hpos, b_vpos, b_fc, {b_hs, b_vs, b_vis, b_hmax, b_vmax, b_ls, b_fs, b_pe});
    end
    m_n[1] = 0;
    m_d[1] = 0;
    drive_cycle(1);
    drive_cycle(1);
    rst_b = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      drive_cycle(1);
      cnt++;
      if (b_ls) found = 1'b1;
    end
    n_checks++;
    if (!found || cnt !== 69) begin
      n_errors++;
      $display("[TB] FAIL reset_first_strobe: got %0d clks (found=%0d) expected 69", cnt, found);
    end
  endtask

  initial begin
    $display("[TB] starting vga_timing_gen bench");
    test_reset();
    test_small_geometry();
    test_divider();
    test_pause();
    test_reset_async();
    #10;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync driver used by the rbzero top.
- Generates VGA pixel position, sync, blanking and line/frame strobes from one system clock.
- Adds four things the current driver lacks:
  - Programmable timing and sync polarity.
  - An integer clock-to-pixel divider with a pause input.
  - Registered line/frame start strobes that pace the wall tracer.
  - A frame counter.

Parameters:
- H_VIEW, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VIEW, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- H_SYNC_POL, 0: hsync active level (0 = active-low).
- V_SYNC_POL, 0: vsync active level (0 = active-low).
- CLK_DIV, 1: clk cycles per pixel; must be >= 1.
- W, 10: width of hpos/vpos; H_TOTAL-1 and V_TOTAL-1 must fit in W bits.

Ports:
- clk  in  1: system clock; all state changes on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- i_enable  in  1: 1 = timing runs; 0 = all state frozen.
- o_pix_en  out  1: pixel-advance strobe.
- hpos  out  W: current horizontal pixel position.
- vpos  out  W: current line.
- o_hsync  out  1: horizontal sync at the H_SYNC_POL level.
- o_vsync  out  1: vertical sync at the V_SYNC_POL level.
- visible  out  1: pixel is in the active area.
- hmax  out  1: hpos == H_TOTAL-1.
- vmax  out  1: vpos == V_TOTAL-1.
- o_line_start  out  1: one-clk pulse at the start of each line.
- o_frame_start  out  1: one-clk pulse at the start of each frame.
- o_frame_count  out  8: frames completed, mod 256.

Behaviour:
- Derived totals:
  - H_TOTAL = H_VIEW+H_FRONT+H_SYNC+H_BACK (800 at defaults).
  - V_TOTAL = V_VIEW+V_FRONT+V_SYNC+V_BACK (525 at defaults).
- Reset (reset_n=0, effective immediately, independent of clk):
  - div_cnt=0, hpos=0, vpos=0, o_frame_count=0.
  - o_line_start=0, o_frame_start=0.
  - Decoded outputs follow the counters: visible=1, hmax=0, vmax=0, syncs at inactive level.
  - Reset asserted mid-line or mid-frame aborts the scan; no strobe is emitted on release.
- Divider and pixel strobe:
  - div_cnt counts 0..CLK_DIV-1 while i_enable=1 and wraps to 0.
  - o_pix_en = i_enable && div_cnt==CLK_DIV-1. This is combinational from registered state.
  - With CLK_DIV=1, o_pix_en = i_enable.
- Counters (update only on clk edges where o_pix_en=1):
  - If hpos != H_TOTAL-1: hpos increments.
  - Else: hpos goes to 0, and vpos increments, or goes to 0 if vpos == V_TOTAL-1.
  - When vpos wraps, o_frame_count increments and wraps 255 -> 0.
- Combinational decodes from the registered counters, with zero latency relative to hpos/vpos:
  - visible = (hpos < H_VIEW) && (vpos < V_VIEW).
  - hsync active when H_VIEW+H_FRONT <= hpos < H_VIEW+H_FRONT+H_SYNC. o_hsync = active ? H_SYNC_POL : ~H_SYNC_POL.
  - vsync active when V_VIEW+V_FRONT <= vpos < V_VIEW+V_FRONT+V_SYNC. o_vsync is polarised the same way with V_SYNC_POL.
  - hmax and vmax are pure equality compares against H_TOTAL-1 and V_TOTAL-1.
- Strobes (registered):
  - o_line_start = 1 for exactly one clk, the cycle after the edge where hpos wrapped to 0.
  - o_frame_start = 1 in that same cycle when vpos also wrapped to 0. It therefore coincides with o_line_start.
  - Both are 0 at all other times, including after reset.
- Pause (i_enable=0):
  - div_cnt, hpos, vpos and o_frame_count hold.
  - o_pix_en=0.
  - A strobe already registered still completes its single cycle, then drops.
  - On re-enable, counting resumes from the held div_cnt value.
- Tracer pacing: ~hmax remains the tracer run signal. o_line_start marks new-row latch timing.

Test Plan:
- Defaults, CLK_DIV=1, enable held high for 2 frames:
  - 800 clks per line and 525 lines per frame (420000 clks/frame).
  - o_hsync low exactly for hpos 656..751.
  - o_vsync low exactly for vpos 490..491.
  - visible count = 307200 per frame.
  - o_frame_count 0 -> 1 -> 2.
- CLK_DIV=3:
  - o_pix_en high every 3rd clk.
  - hpos steps once per 3 clks.
  - Line = 2400 clks; o_line_start pulses once per line, each 1 clk wide.
- i_enable deasserted at hpos=100, vpos=5 for 50 clks:
  - hpos/vpos/div_cnt frozen and o_pix_en=0 throughout.
  - After re-enable, the next line start is 50 clks later than in an unpaused run.
- reset_n pulsed low asynchronously mid-clock at hpos=700, vpos=300:
  - Outputs go to reset values before the next clk edge.
  - No o_line_start pulse on release.
  - First strobe arrives H_TOTAL clks later.
- H_VIEW=4, H_FRONT=H_SYNC=H_BACK=1, V_VIEW=2, V_FRONT=V_SYNC=V_BACK=1, H_SYNC_POL=V_SYNC_POL=1, run 257 frames:
  - o_hsync high only at hpos=5; o_vsync high only at vpos=3.
  - o_frame_start coincides with o_line_start at vpos=0.
  - o_frame_count wraps 255 -> 0 and reads 1 at the end.
